vector_sqrt_seq: RTL

Lane sequencer directly upstream of the scalar fp16 `sqrt` unit. It accepts one LANES-wide fp16 vector from the vector datapath and issues each active lane to the single-outstanding `sqrt` unit in ascending lane order. It collects the results and presents the completed vector downstream with a valid/ready handshake. Masked lanes bypass the `sqrt` unit and are returned unchanged.

---
 rtl/vector_pkg.sv | 15 +
 rtl/lane_pick.sv | 22 ++
 rtl/vector_sqrt_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared vector-datapath types: fp16 lane type and the sqrt lane-sequencer state encoding.
package vector_pkg;

    typedef logic [15:0] fp16_t;

    localparam int VSQ_LANES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } vsq_state_t;

endpackage

// File: rtl/lane_pick.sv
// Priority pick of the lowest set bit of a pending-lane mask.
module lane_pick #(
    parameter int LANES = 16
) (
    input  logic [LANES-1:0]         pending,
    output logic [$clog2(LANES)-1:0] cur,
    output logic                     any
);

    localparam int IDX_W = $clog2(LANES);

    // NOTE: cur gets a default before the loop so an all-zero mask cannot infer a latch.
    always_comb begin
        cur = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pending[i]) cur = IDX_W'(i);
        end
    end

    assign any = |pending;

endmodule

// File: rtl/vector_sqrt_seq.sv
// Issues the active lanes of one fp16 vector to a single-outstanding sqrt unit, lowest lane first,
// and returns the completed vector; masked lanes pass through untouched.
module vector_sqrt_seq
    import vector_pkg::*;
#(
    parameter int LANES = VSQ_LANES_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    vec_valid_in,
    output logic                    vec_ready_out,
    input  fp16_t [LANES-1:0]       vec_in,
    input  logic  [LANES-1:0]       lane_mask,
    input  logic                    sq_ready_in,
    output logic                    sq_valid_out,
    output fp16_t                   sq_data_out,
    input  logic                    sq_valid_in,
    input  fp16_t                   sq_data_in,
    output logic                    vec_valid_out,
    input  logic                    vec_ready_in,
    output fp16_t [LANES-1:0]       vec_out,
    output logic                    stray_err
);

    localparam int IDX_W = $clog2(LANES);

    vsq_state_t        state;
    logic [LANES-1:0]  pending;
    fp16_t [LANES-1:0] res_buf;
    logic [IDX_W-1:0]  inflight;
    logic [IDX_W-1:0]  cur;
    logic              any;

    lane_pick #(.LANES(LANES)) u_pick (
        .pending (pending),
        .cur     (cur),
        .any     (any)
    );

    assign vec_ready_out = (state == IDLE);
    assign vec_valid_out = (state == DONE);
    assign sq_valid_out  = (state == ISSUE) && sq_ready_in;
    assign sq_data_out   = res_buf[cur];
    assign vec_out       = res_buf;

    // NOTE: all state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            pending   <= '0;
            // NOTE: the result buffer is reset so sq_data_out and vec_out never carry X.
            res_buf   <= '0;
            inflight  <= '0;
            stray_err <= 1'b0;
        end else begin
            // A result outside WAIT has no owner lane; flag it and drop the data.
            if (sq_valid_in && state != WAIT) stray_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (vec_valid_in) begin
                        res_buf <= vec_in;
                        pending <= lane_mask;
                        state   <= (|lane_mask) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (sq_ready_in) begin
                        pending[cur] <= 1'b0;
                        inflight     <= cur;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // pending already excludes the in-flight lane, so 'any' means more work remains.
                    if (sq_valid_in) begin
                        res_buf[inflight] <= sq_data_in;
                        state             <= any ? ISSUE : DONE;
                    end
                end
                DONE: begin
                    if (vec_ready_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
